// File: rtl/lfsr.sv
// Fibonacci XOR LFSR, shift-left, with a built-in maximal-length tap table selected by width N.
// Asynchronous active-high reset forces all ones; a seed load overrides the shift.
module lfsr #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         load_seed,
  input  logic [N-1:0] seed_data,
  output logic [N-1:0] lfsr_data
);

  if (N < 2 || N > 32) begin : g_bad_width
    $error("lfsr: N must be in the range 2..32");
  end

  // Bit k-1 set means tap k feeds the XOR.
  function automatic logic [31:0] tap_mask(input int unsigned n);
    case (n)
      2:       tap_mask = 32'h0000_0003;
      3:       tap_mask = 32'h0000_0006;
      4:       tap_mask = 32'h0000_000C;
      5:       tap_mask = 32'h0000_0014;
      6:       tap_mask = 32'h0000_0030;
      7:       tap_mask = 32'h0000_0060;
      8:       tap_mask = 32'h0000_00B8;
      9:       tap_mask = 32'h0000_0110;
      10:      tap_mask = 32'h0000_0240;
      11:      tap_mask = 32'h0000_0500;
      12:      tap_mask = 32'h0000_0829;
      13:      tap_mask = 32'h0000_100D;
      14:      tap_mask = 32'h0000_2015;
      15:      tap_mask = 32'h0000_6000;
      16:      tap_mask = 32'h0000_D008;
      17:      tap_mask = 32'h0001_2000;
      18:      tap_mask = 32'h0002_0400;
      19:      tap_mask = 32'h0004_0023;
      20:      tap_mask = 32'h0009_0000;
      21:      tap_mask = 32'h0014_0000;
      22:      tap_mask = 32'h0030_0000;
      23:      tap_mask = 32'h0042_0000;
      24:      tap_mask = 32'h00E1_0000;
      25:      tap_mask = 32'h0120_0000;
      26:      tap_mask = 32'h0200_0023;
      27:      tap_mask = 32'h0400_0013;
      28:      tap_mask = 32'h0900_0000;
      29:      tap_mask = 32'h1400_0000;
      30:      tap_mask = 32'h2000_0029;
      31:      tap_mask = 32'h4800_0000;
      32:      tap_mask = 32'h8020_0003;
      default: tap_mask = 32'h0000_0000;
    endcase
  endfunction

  localparam logic [31:0]  TapMask = tap_mask(N);
  localparam logic [N-1:0] TapBits = TapMask[N-1:0];
  localparam logic [N-1:0] SeedOne = {{(N - 1){1'b0}}, 1'b1};

  logic [N-1:0] r_state;
  logic [N-1:0] w_next;
  logic         w_fb;

  always_comb begin
    w_fb   = ^(r_state & TapBits);
    w_next = {r_state[N-2:0], w_fb};
    if (load_seed) begin
      // All zeros would lock the register up, so substitute 1.
      w_next = (seed_data == '0) ? SeedOne : seed_data;
    end
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      r_state <= '1;
    end else begin
      r_state <= w_next;
    end
  end

  assign lfsr_data = r_state;

endmodule

// File: tb/tb_lfsr.sv
// Self-checking bench for lfsr: directed N=4 scenarios, randomized N=4 run against a tap-table
// model, and full-period runs for N=3, 8 and 16.
module tb_lfsr;

  logic        clk;
  logic        resetn;
  logic        load4, load3, load8, load16;
  logic [3:0]  seed4;
  logic [2:0]  seed3;
  logic [7:0]  seed8;
  logic [15:0] seed16;
  logic [3:0]  q4;
  logic [2:0]  q3;
  logic [7:0]  q8;
  logic [15:0] q16;

  int checks = 0;
  int errors = 0;

  lfsr #(.N(4)) u_dut4 (
    .clk(clk), .resetn(resetn), .load_seed(load4), .seed_data(seed4), .lfsr_data(q4)
  );
  lfsr #(.N(3)) u_dut3 (
    .clk(clk), .resetn(resetn), .load_seed(load3), .seed_data(seed3), .lfsr_data(q3)
  );
  lfsr #(.N(8)) u_dut8 (
    .clk(clk), .resetn(resetn), .load_seed(load8), .seed_data(seed8), .lfsr_data(q8)
  );
  lfsr #(.N(16)) u_dut16 (
    .clk(clk), .resetn(resetn), .load_seed(load16), .seed_data(seed16), .lfsr_data(q16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Tap numbers straight from the table, one per byte, zero = unused.
  function automatic logic [31:0] taps_of(input int n);
    case (n)
      3:       taps_of = {8'd0, 8'd0, 8'd3, 8'd2};
      4:       taps_of = {8'd0, 8'd0, 8'd4, 8'd3};
      8:       taps_of = {8'd8, 8'd6, 8'd5, 8'd4};
      16:      taps_of = {8'd16, 8'd15, 8'd13, 8'd4};
      default: taps_of = 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] model_next(input int n, input logic [31:0] q,
                                              input logic load, input logic [31:0] seed);
    logic [31:0] mask;
    logic [31:0] t;
    logic        fb;
    int          k;
    mask = (32'd1 << n) - 32'd1;
    if (load) begin
      if ((seed & mask) == 32'd0) return 32'd1;
      return seed & mask;
    end
    t  = taps_of(n);
    fb = 1'b0;
    for (int i = 0; i < 4; i++) begin
      k = int'(t[8*i +: 8]);
      if (k != 0) fb = fb ^ q[k-1];
    end
    return ((q << 1) | {31'd0, fb}) & mask;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect4(input string name, input int exp);
    checks++;
    if (q4 !== 4'(exp)) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, q4, exp);
    end
  endtask

  task automatic test_reset();
    int exp_seq[3] = '{14, 12, 8};
    resetn = 1'b1;
    #2;
    expect4("reset_before_edge", 15);
    load4 = 1'b1;
    seed4 = 4'd5;
    tick();
    expect4("reset_ignores_load", 15);
    load4  = 1'b0;
    resetn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect4("after_reset_step", exp_seq[i]);
    end
  endtask

  task automatic test_load_hold();
    int          exp_seq[4] = '{14, 12, 8, 1};
    logic [31:0] m;
    load4 = 1'b1;
    seed4 = 4'hF;
    tick();
    expect4("hold_load_1", 15);
    tick();
    expect4("hold_load_2", 15);
    load4 = 1'b0;
    m     = 32'd15;
    for (int i = 0; i < 15; i++) begin
      tick();
      m = model_next(4, m, 1'b0, 32'd0);
      if (i < 4) expect4("seq_from_15", exp_seq[i]);
      else expect4("seq_model", int'(m));
    end
    expect4("wrap_after_15", 15);
  endtask

  task automatic test_zero_seed();
    int exp_seq[3] = '{2, 4, 9};
    load4 = 1'b1;
    seed4 = 4'd0;
    tick();
    expect4("zero_seed_load", 1);
    load4 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect4("zero_seed_step", exp_seq[i]);
    end
  endtask

  task automatic test_mid_load();
    int exp_seq[3] = '{11, 7, 15};
    tick();
    tick();
    load4 = 1'b1;
    seed4 = 4'd5;
    tick();
    expect4("mid_load", 5);
    load4 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect4("mid_load_step", exp_seq[i]);
    end
  endtask

  task automatic test_async_reset();
    tick();
    tick();
    tick();
    resetn = 1'b1;
    #2;
    expect4("async_reset_now", 15);
    resetn = 1'b0;
    tick();
    expect4("async_reset_resume", 14);
    // Reset held across an edge while a load is requested.
    load4 = 1'b1;
    seed4 = 4'd9;
    #2;
    resetn = 1'b1;
    #1;
    expect4("reset_in_load_now", 15);
    tick();
    expect4("reset_in_load_edge", 15);
    resetn = 1'b0;
    load4  = 1'b0;
    tick();
    expect4("reset_in_load_resume", 14);
  endtask

  task automatic test_random();
    logic [31:0] m;
    logic        ld;
    logic [3:0]  sd;
    m = 32'(q4);
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        resetn = 1'b1;
        #1;
        m = 32'd15;
        expect4("rand_async_reset", 15);
        resetn = 1'b0;
      end
      ld = ($urandom_range(0, 3) == 0);
      sd = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      load4 = ld;
      seed4 = sd;
      tick();
      m = model_next(4, m, ld, 32'(sd));
      expect4("rand_model", int'(m));
    end
    load4 = 1'b0;
  endtask

  task automatic test_period();
    bit          seen3[8];
    bit          seen8[256];
    bit          seen16[65536];
    logic [31:0] m3, m8, m16;
    int          mis3, mis8, mis16, z3, z8, z16, rep3, rep8, rep16, ret3, ret8, ret16;
    mis3 = 0; mis8 = 0; mis16 = 0; z3 = 0; z8 = 0; z16 = 0;
    rep3 = 0; rep8 = 0; rep16 = 0; ret3 = 0; ret8 = 0; ret16 = 0;
    resetn = 1'b1;
    tick();
    resetn = 1'b0;
    m3 = 32'd7; m8 = 32'd255; m16 = 32'd65535;
    seen3[7] = 1'b1; seen8[255] = 1'b1; seen16[65535] = 1'b1;
    for (int cyc = 1; cyc <= 65535; cyc++) begin
      tick();
      m3  = model_next(3, m3, 1'b0, 32'd0);
      m8  = model_next(8, m8, 1'b0, 32'd0);
      m16 = model_next(16, m16, 1'b0, 32'd0);
      if (32'(q3) !== m3) mis3++;
      if (32'(q8) !== m8) mis8++;
      if (32'(q16) !== m16) mis16++;
      if (q3 == 3'd0) z3++;
      if (q8 == 8'd0) z8++;
      if (q16 == 16'd0) z16++;
      if (ret3 == 0) begin
        if (q3 == 3'h7) ret3 = cyc;
        else if (seen3[q3]) rep3++;
        else seen3[q3] = 1'b1;
      end
      if (ret8 == 0) begin
        if (q8 == 8'hFF) ret8 = cyc;
        else if (seen8[q8]) rep8++;
        else seen8[q8] = 1'b1;
      end
      if (ret16 == 0) begin
        if (q16 == 16'hFFFF) ret16 = cyc;
        else if (seen16[q16]) rep16++;
        else seen16[q16] = 1'b1;
      end
    end
    checks++; if (ret3 != 7)      begin errors++; $display("FAIL period_n3: got %0d expected 7", ret3); end
    checks++; if (ret8 != 255)    begin errors++; $display("FAIL period_n8: got %0d expected 255", ret8); end
    checks++; if (ret16 != 65535) begin errors++; $display("FAIL period_n16: got %0d expected 65535", ret16); end
    checks++; if (mis3 != 0)  begin errors++; $display("FAIL model_n3: %0d mismatches, expected 0", mis3); end
    checks++; if (mis8 != 0)  begin errors++; $display("FAIL model_n8: %0d mismatches, expected 0", mis8); end
    checks++; if (mis16 != 0) begin errors++; $display("FAIL model_n16: %0d mismatches, expected 0", mis16); end
    checks++; if (z3 + z8 + z16 != 0) begin
      errors++; $display("FAIL zero_state: got %0d/%0d/%0d zero states, expected 0", z3, z8, z16);
    end
    checks++; if (rep3 + rep8 + rep16 != 0) begin
      errors++; $display("FAIL early_repeat: got %0d/%0d/%0d repeats, expected 0", rep3, rep8, rep16);
    end
  endtask

  initial begin
    resetn = 1'b0;
    load4 = 1'b0; load3 = 1'b0; load8 = 1'b0; load16 = 1'b0;
    seed4 = '0; seed3 = '0; seed8 = '0; seed16 = '0;
    test_reset();
    test_load_hold();
    test_zero_seed();
    test_mid_load();
    test_async_reset();
    test_random();
    test_period();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
